// File: rtl/axis_out_gearbox.sv
// -----------------------------------------------------------------------------
// axis_out_gearbox
//   Buffers wide PPU vectors in a small FIFO and serializes each vector into
//   RATIO = IN_W/OUT_W AXI-Stream beats. Supports packet framing by vector
//   count (tlast), selectable slice order, synchronous flush and a sticky
//   overflow flag for vectors offered while the FIFO is full.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   i_valid/i_ready   : vector input handshake (i_ready = FIFO not full)
//   i_data            : IN_W-bit input vector
//   cfg_pkt_len       : vectors per packet, 0 = never assert tlast
//   cfg_msb_first     : 1 = send top slice first (sampled per vector)
//   i_flush           : synchronous flush of FIFO, serializer and packet count
//   i_ovf_clr         : clears the sticky overflow flag
//   m_axis_*          : AXI-Stream master (tdata/tvalid/tready/tlast)
//   o_overflow        : sticky, a vector was dropped
//   o_fifo_count      : FIFO occupancy
//   o_busy            : FIFO non-empty or a beat is being presented
// -----------------------------------------------------------------------------
module axis_out_gearbox #(
    parameter int IN_W       = 128,  // multiple of OUT_W, IN_W/OUT_W a power of two >= 2
    parameter int OUT_W      = 64,
    parameter int FIFO_DEPTH = 4,    // power of two >= 2
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    output logic                        i_ready,
    input  logic [IN_W-1:0]             i_data,
    input  logic [CNT_W-1:0]            cfg_pkt_len,
    input  logic                        cfg_msb_first,
    input  logic                        i_flush,
    input  logic                        i_ovf_clr,
    output logic [OUT_W-1:0]            m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        o_overflow,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_busy
);

    localparam int RATIO  = IN_W / OUT_W;
    localparam int BEAT_W = $clog2(RATIO);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    // ------------------------------------------------------------------ FIFO
    logic [IN_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [FCNT_W-1:0] r_count;
    logic              r_ready_en;   // low during reset and for one edge after
    logic              r_ovf;

    logic w_push, w_pop, w_fifo_nempty;

    assign w_fifo_nempty = (r_count != '0);
    // Full is judged on registered occupancy only, so a pop in the same cycle
    // never frees a slot for the incoming vector.
    assign i_ready = r_ready_en && (r_count != FCNT_W'(FIFO_DEPTH)) && !i_flush;
    assign w_push  = i_valid && i_ready;

    // NOTE: storage arrays carry no reset; pointers and count define validity,
    // and leaving the RAM unreset lets it map onto plain memory cells.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            // A refused vector (full or flushing) sets the flag; set beats clear.
            if (i_valid && !i_ready) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------ serializer
    state_t            r_state, w_state_nxt;
    logic [BEAT_W-1:0] r_beat, w_beat_nxt;
    logic [IN_W-1:0]   r_shift;
    logic              r_msb;        // slice order latched for the vector in flight
    logic [CNT_W-1:0]  r_vec_cnt;    // completed vectors in the current packet

    logic              w_send, w_last_beat, w_vec_done, w_tlast;
    logic [BEAT_W-1:0] w_slice_idx;
    logic [OUT_W-1:0]  w_slices [RATIO];

    assign w_send      = (r_state == S_SEND);
    assign w_last_beat = (r_beat == BEAT_W'(RATIO - 1));
    // cfg_pkt_len is compared live; a count already past it only matches again
    // after wrapping through 2^CNT_W.
    assign w_tlast     = w_send && w_last_beat && (cfg_pkt_len != '0) &&
                         ((r_vec_cnt + 1'b1) == cfg_pkt_len);

    // NOTE: all combinational outputs get a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_pop       = 1'b0;
        w_vec_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nempty) begin
                    w_pop       = 1'b1;
                    w_beat_nxt  = '0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    if (!w_last_beat) begin
                        w_beat_nxt = r_beat + 1'b1;
                    end else begin
                        w_vec_done = 1'b1;
                        // Chain straight into the next vector to avoid a bubble.
                        if (w_fifo_nempty) begin
                            w_pop      = 1'b1;
                            w_beat_nxt = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_msb     <= 1'b0;
            r_vec_cnt <= '0;
        end else if (i_flush) begin
            r_vec_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
                r_msb   <= cfg_msb_first;
            end
            if (w_vec_done) begin
                r_vec_cnt <= w_tlast ? '0 : r_vec_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign w_slices[g] = r_shift[g*OUT_W +: OUT_W];
    end

    // With RATIO a power of two, RATIO-1-beat is the bitwise inverse of beat.
    assign w_slice_idx = r_msb ? ~r_beat : r_beat;

    // ---------------------------------------------------------------- outputs
    assign m_axis_tvalid = w_send;
    assign m_axis_tdata  = w_send ? w_slices[w_slice_idx] : '0;
    assign m_axis_tlast  = w_tlast;
    assign o_overflow    = r_ovf;
    assign o_fifo_count  = r_count;
    assign o_busy        = w_fifo_nempty || w_send;

endmodule

// File: tb/tb_axis_out_gearbox.sv
module tb_axis_out_gearbox;

    localparam int IN_W       = 128;
    localparam int OUT_W      = 64;
    localparam int RATIO      = IN_W / OUT_W;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_valid;
    logic                 i_ready;
    logic [IN_W-1:0]      i_data;
    logic [CNT_W-1:0]     cfg_pkt_len;
    logic                 cfg_msb_first;
    logic                 i_flush;
    logic                 i_ovf_clr;
    logic [OUT_W-1:0]     m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 o_overflow;
    logic [2:0]           o_fifo_count;
    logic                 o_busy;

    axis_out_gearbox #(
        .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .cfg_pkt_len(cfg_pkt_len), .cfg_msb_first(cfg_msb_first),
        .i_flush(i_flush), .i_ovf_clr(i_ovf_clr),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .o_overflow(o_overflow), .o_fifo_count(o_fifo_count), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected beat stream, built per accepted vector.
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;
    beat_t exp_q[$];
    int    vec_num = 0;   // vectors accepted since the packet count last restarted

    logic [IN_W-1:0] a, b, c, d, e, f, g, h, k, m, n;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [IN_W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic expect_vector(input logic [IN_W-1:0] v, input logic msb);
        beat_t bt;
        int    idx;
        vec_num++;
        for (int bi = 0; bi < RATIO; bi++) begin
            idx     = msb ? (RATIO - 1 - bi) : bi;
            bt.data = v[idx*OUT_W +: OUT_W];
            bt.last = (bi == RATIO - 1) && (cfg_pkt_len != 0) &&
                      ((vec_num % cfg_pkt_len) == 0);
            exp_q.push_back(bt);
        end
    endtask

    // Compare a beat that will be consumed on the coming edge.
    task automatic handle_beat();
        beat_t bt;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("tvalid_unexpected", m_axis_tvalid, 1'b0);
            end else begin
                bt = exp_q.pop_front();
                check("model_tdata", m_axis_tdata, bt.data);
                check("model_tlast", m_axis_tlast, bt.last);
            end
        end
    endtask

    task automatic run_random(input int ncyc, input int vprob, input int rprob);
        for (int i = 0; i < ncyc; i++) begin
            check("model_busy", o_busy, exp_q.size() != 0);
            m_axis_tready = ($urandom_range(99) < rprob);
            handle_beat();
            i_valid = 1'b0;
            if (i_ready && ($urandom_range(99) < vprob)) begin
                i_valid = 1'b1;
                i_data  = rand128();
                expect_vector(i_data, cfg_msb_first);
            end
            cycle();
        end
        i_valid = 1'b0;
    endtask

    task automatic drain_and_check();
        run_random(40, 0, 100);
        check("drain_empty", exp_q.size(), 0);
        check("drain_busy", o_busy, 1'b0);
    endtask

    // Two vectors with cfg_pkt_len=2, LSB-first, tready=1, packet count at 0:
    // four back-to-back beats with tlast only on the fourth.
    task automatic push2_and_check(input string tag, input logic [IN_W-1:0] v0, input logic [IN_W-1:0] v1);
        logic [IN_W-1:0] v;
        i_valid = 1'b1;
        i_data  = v0;
        cycle();
        check($sformatf("%s_latency", tag), m_axis_tvalid, 1'b0);
        i_data = v1;
        cycle();
        i_valid = 1'b0;
        for (int bi = 0; bi < 4; bi++) begin
            v = (bi < 2) ? v0 : v1;
            check($sformatf("%s_tvalid%0d", tag, bi), m_axis_tvalid, 1'b1);
            check($sformatf("%s_tdata%0d", tag, bi), m_axis_tdata, v[(bi%2)*OUT_W +: OUT_W]);
            check($sformatf("%s_tlast%0d", tag, bi), m_axis_tlast, bi == 3);
            cycle();
        end
        check($sformatf("%s_idle", tag), m_axis_tvalid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_flush = 1'b0; i_ovf_clr = 1'b0;
        cfg_msb_first = 1'b0; cfg_pkt_len = 16'd2; m_axis_tready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_ovf", o_overflow, 1'b0);
        check("rst_count", o_fifo_count, 3'd0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_ready", i_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_pre_edge", i_ready, 1'b0);
        @(negedge clk);
        check("ready_post_edge", i_ready, 1'b1);

        // Two-vector packet, LSB slice first
        a = {{16{4'h1}}, {16{4'h2}}};
        b = rand128();
        push2_and_check("pkt2", a, b);

        // MSB-first with a stall held across two cycles
        cfg_msb_first = 1'b1; cfg_pkt_len = 16'd1; c = rand128();
        i_valid = 1'b1; i_data = c; cycle();
        i_valid = 1'b0; cycle();
        m_axis_tready = 1'b1;
        check("msb_hi_valid", m_axis_tvalid, 1'b1);
        check("msb_hi_data", m_axis_tdata, c[127:64]);
        check("msb_hi_last", m_axis_tlast, 1'b0);
        cycle();
        m_axis_tready = 1'b0;
        check("msb_lo_data", m_axis_tdata, c[63:0]);
        check("msb_lo_last", m_axis_tlast, 1'b1);
        cycle();
        check("stall1_valid", m_axis_tvalid, 1'b1);
        check("stall1_data", m_axis_tdata, c[63:0]);
        check("stall1_last", m_axis_tlast, 1'b1);
        cycle();
        check("stall2_data", m_axis_tdata, c[63:0]);
        check("stall2_last", m_axis_tlast, 1'b1);
        m_axis_tready = 1'b1;
        cycle();
        check("msb_done", m_axis_tvalid, 1'b0);

        // Overflow: one vector parked in the serializer, then five pushes into
        // the FIFO with tready low -- four fit, the fifth is dropped.
        cfg_msb_first = 1'b0; cfg_pkt_len = 16'd0; m_axis_tready = 1'b0;
        i_valid = 1'b1; i_data = rand128(); cycle();
        i_valid = 1'b0; cycle();
        check("park_valid", m_axis_tvalid, 1'b1);
        check("park_count", o_fifo_count, 3'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_ready%0d", i), i_ready, i < 4);
            i_valid = 1'b1; i_data = rand128();
            cycle();
        end
        i_valid = 1'b0;
        check("ovf_set", o_overflow, 1'b1);
        check("ovf_count", o_fifo_count, 3'd4);
        check("ovf_ready", i_ready, 1'b0);
        i_ovf_clr = 1'b1; cycle();
        check("ovf_clr", o_overflow, 1'b0);
        i_valid = 1'b1; cycle();   // drop and clear on the same edge
        i_valid = 1'b0; i_ovf_clr = 1'b0;
        check("ovf_set_wins", o_overflow, 1'b1);
        i_flush = 1'b1; cycle(); i_flush = 1'b0;
        check("flush_count", o_fifo_count, 3'd0);
        check("flush_valid", m_axis_tvalid, 1'b0);
        check("flush_keeps_ovf", o_overflow, 1'b1);
        i_ovf_clr = 1'b1; cycle(); i_ovf_clr = 1'b0;
        check("ovf_clr2", o_overflow, 1'b0);

        // Flush after beat 0 of the second vector of a packet
        cfg_pkt_len = 16'd2; m_axis_tready = 1'b1;
        d = rand128(); e = rand128();
        i_valid = 1'b1; i_data = d; cycle();
        i_data = e; cycle();
        i_valid = 1'b0;
        check("fl_d_lo", m_axis_tdata, d[63:0]); cycle();
        check("fl_d_hi", m_axis_tdata, d[127:64]);
        check("fl_d_last", m_axis_tlast, 1'b0); cycle();
        check("fl_e_lo", m_axis_tdata, e[63:0]);
        i_flush = 1'b1;
        #1;
        check("flush_ready", i_ready, 1'b0);
        cycle(); i_flush = 1'b0;
        check("fl_valid", m_axis_tvalid, 1'b0);
        check("fl_count", o_fifo_count, 3'd0);
        f = rand128(); g = rand128();
        push2_and_check("postflush", f, g);

        // Reset mid-packet
        h = rand128(); k = rand128();
        i_valid = 1'b1; i_data = h; cycle();
        i_data = k; cycle();
        i_valid = 1'b0;
        check("rs_h_lo", m_axis_tdata, h[63:0]); cycle();
        check("rs_h_hi", m_axis_tdata, h[127:64]); cycle();
        check("rs_k_lo", m_axis_tdata, k[63:0]);
        #2 rst = 1'b1;
        #1;
        check("arst_tvalid", m_axis_tvalid, 1'b0);
        check("arst_tdata", m_axis_tdata, '0);
        check("arst_count", o_fifo_count, 3'd0);
        check("arst_ready", i_ready, 1'b0);
        check("arst_busy", o_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        m = rand128(); n = rand128();
        push2_and_check("postrst", m, n);

        // Back-to-back vectors: tvalid must stay high across vector boundaries
        cfg_pkt_len = 16'd3; cfg_msb_first = 1'b1; m_axis_tready = 1'b1;
        vec_num = 0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("b2b_tvalid%0d", i), m_axis_tvalid, (i >= 2) && (i <= 7));
            handle_beat();
            i_valid = (i < 3);
            if (i < 3) begin
                i_data = rand128();
                expect_vector(i_data, cfg_msb_first);
            end
            cycle();
        end
        i_valid = 1'b0;
        check("b2b_empty", exp_q.size(), 0);

        // Randomized traffic, LSB-first, 3-vector packets
        cfg_msb_first = 1'b0;
        run_random(400, 50, 60);
        drain_and_check();

        // Randomized traffic, MSB-first, 5-vector packets, count restarted by flush
        i_flush = 1'b1; cycle(); i_flush = 1'b0;
        vec_num = 0;
        cfg_msb_first = 1'b1; cfg_pkt_len = 16'd5;
        run_random(400, 70, 80);
        drain_and_check();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
